// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - traffic phase sequencer with round-robin priority phases (optional ALLRED via PHASE_SEQ_ALLRED_EN)
module phase_sequencer #(
    parameter int N_BASE       = 2,
    parameter int N_PRI        = 2,
    parameter int TW           = 8,
    parameter int GREEN_TICKS  = 4,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    localparam int PW          = $clog2(N_BASE + N_PRI)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [N_PRI-1:0] pri_req,
    input  logic             hold,
    output logic [PW-1:0]    current_phase,
    output logic [1:0]       light_state,
    output logic [N_PRI-1:0] pri_grant,
    output logic             phase_done
);

    localparam int RW = (N_PRI > 1) ? $clog2(N_PRI) : 1;

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2
    } state_t;

    localparam logic [TW-1:0] G_LOAD = TW'(GREEN_TICKS - 1);
    localparam logic [TW-1:0] Y_LOAD = TW'(YELLOW_TICKS - 1);
`ifdef PHASE_SEQ_ALLRED_EN
    localparam logic [TW-1:0] A_LOAD = TW'(ALLRED_TICKS - 1);
    localparam state_t        S_LAST = S_ALLRED;
`else
    localparam state_t        S_LAST = S_YELLOW;
`endif

    state_t             state;
    logic [TW-1:0]      timer;
    logic [N_PRI-1:0]   pend;
    logic [RW-1:0]      rr_ptr;

    logic               found;
    logic [RW-1:0]      k_sel;
    logic [N_PRI-1:0]   k_onehot;
    logic [RW-1:0]      rr_next;
    logic               grant_now;
    logic               advance;
    logic [PW-1:0]      next_phase;

    // Round-robin search of the pending latch, starting at rr_ptr and wrapping
    always_comb begin
        int j;
        found = 1'b0;
        k_sel = '0;
        j     = 0;
        for (int i = 0; i < N_PRI; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N_PRI) j = j - N_PRI;
            if (!found && pend[RW'(j)]) begin
                found = 1'b1;
                k_sel = RW'(j);
            end
        end
    end

    always_comb begin
        k_onehot        = '0;
        k_onehot[k_sel] = 1'b1;
        rr_next         = (k_sel == RW'(N_PRI - 1)) ? '0 : k_sel + RW'(1);
        grant_now       = (current_phase == PW'(N_BASE - 1)) && found;
        advance         = tick && (timer == '0) && (state == S_LAST);
        if (current_phase < PW'(N_BASE - 1))
            next_phase = current_phase + PW'(1);
        else if (grant_now)
            next_phase = PW'(N_BASE) + PW'(k_sel);
        else
            next_phase = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_GREEN;
            timer         <= G_LOAD;
            pend          <= '0;
            rr_ptr        <= '0;
            current_phase <= '0;
            pri_grant     <= '0;
            phase_done    <= 1'b0;
        end else begin
            phase_done <= 1'b0;
            pend       <= pend | pri_req;
            if (advance) begin
                state         <= S_GREEN;
                timer         <= G_LOAD;
                current_phase <= next_phase;
                phase_done    <= 1'b1;
                if (grant_now) begin
                    pri_grant     <= k_onehot;
                    rr_ptr        <= rr_next;
                    // a request still held re-latches instead of being lost
                    pend[k_sel]   <= pri_req[k_sel];
                end else begin
                    pri_grant <= '0;
                end
            end else if (tick) begin
                case (state)
                    S_GREEN: begin
                        if (timer == '0) begin
                            state <= S_YELLOW;
                            timer <= Y_LOAD;
                        end else if (!hold) begin
                            timer <= timer - TW'(1);
                        end
                    end
`ifdef PHASE_SEQ_ALLRED_EN
                    S_YELLOW: begin
                        if (timer == '0) begin
                            state <= S_ALLRED;
                            timer <= A_LOAD;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    S_ALLRED: timer <= timer - TW'(1);
`else
                    S_YELLOW: timer <= timer - TW'(1);
`endif
                    default: begin
                        state <= S_GREEN;
                        timer <= G_LOAD;
                    end
                endcase
            end
        end
    end

    assign light_state = state;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed scoreboard bench for phase_sequencer
module tb_phase_sequencer;

    localparam int G = 4;
    localparam int Y = 2;
`ifdef PHASE_SEQ_ALLRED_EN
    localparam int R  = 1;
    localparam int LR = 2;
`else
    localparam int R  = 0;
    localparam int LR = 0;
`endif
    localparam int P = G + Y + R;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b1;
    logic       hold = 1'b0;
    logic [1:0] pri_req = 2'b00;
    logic [1:0] current_phase;
    logic [1:0] light_state;
    logic [1:0] pri_grant;
    logic       phase_done;

    phase_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick          (tick),
        .pri_req       (pri_req),
        .hold          (hold),
        .current_phase (current_phase),
        .light_state   (light_state),
        .pri_grant     (pri_grant),
        .phase_done    (phase_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int gr;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic expect_done(input int ph, input int gr, input int c);
        exp_t e;
        e.ph  = ph;
        e.gr  = gr;
        e.cyc = c;
        q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (phase_done !== 1'b0) begin
            if (q.size() == 0) begin
                chk("unexpected_done_cycle", cyc, 0);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_phase", current_phase, e.ph);
                chk("done_grant", pri_grant, e.gr);
            end
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic drained();
        chk("scoreboard_drained", q.size(), 0);
        q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_phase"}, current_phase, 0);
        chk({tag, "_light"}, light_state, 0);
        chk({tag, "_grant"}, pri_grant, 0);
        chk({tag, "_done"}, phase_done, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        // 1: plain base cycling
        do_reset();
        expect_done(1, 0, P);
        expect_done(0, 0, 2 * P);
        expect_done(1, 0, 3 * P);
        run_to(G - 1);
        chk("s1_green_light", light_state, 0);
        step();
        chk("s1_yellow_light", light_state, 1);
        run_to(G + Y);
        chk("s1_after_yellow_light", light_state, LR);
        run_to(3 * P);
        drained();

        // 2: single pulsed request served once
        do_reset();
        expect_done(1, 0, P);
        expect_done(2, 1, 2 * P);
        expect_done(0, 0, 3 * P);
        expect_done(1, 0, 4 * P);
        expect_done(0, 0, 5 * P);
        run_to(2);
        pri_req = 2'b01;
        step();
        pri_req = 2'b00;
        run_to(2 * P + 1);
        chk("s2_grant_held", pri_grant, 1);
        run_to(5 * P);
        drained();

        // 3: both requests held, round-robin alternation
        do_reset();
        pri_req = 2'b11;
        expect_done(1, 0, P);
        expect_done(2, 1, 2 * P);
        expect_done(0, 0, 3 * P);
        expect_done(1, 0, 4 * P);
        expect_done(3, 2, 5 * P);
        expect_done(0, 0, 6 * P);
        expect_done(1, 0, 7 * P);
        expect_done(2, 1, 8 * P);
        run_to(8 * P);
        drained();
        pri_req = 2'b00;

        // 4: hold stretches GREEN but not YELLOW
        do_reset();
        expect_done(1, 0, P + 5);
        expect_done(0, 0, 2 * P + 5);
        hold = 1'b1;
        run_to(5);
        hold = 1'b0;
        run_to(G + 4);
        chk("s4_green_stretched", light_state, 0);
        step();
        chk("s4_yellow_after_hold", light_state, 1);
        run_to(P + 5 + G);
        chk("s4_p1_yellow", light_state, 1);
        hold = 1'b1;
        run_to(P + 5 + G + Y);
        chk("s4_yellow_not_held", light_state, LR);
        hold = 1'b0;
        run_to(2 * P + 5);
        drained();

        // 5: tick every third cycle
        do_reset();
        expect_done(1, 0, 3 * P);
        expect_done(0, 0, 6 * P);
        while (cyc < 6 * P) begin
            tick = ((cyc + 1) % 3 == 0);
            step();
            if (cyc == 3 * G - 1) chk("s5_green_slow", light_state, 0);
            if (cyc == 3 * G)     chk("s5_yellow_slow", light_state, 1);
        end
        tick = 1'b1;
        drained();

        // 6: async reset during phase 1 YELLOW discards pending request
        do_reset();
        expect_done(1, 0, P);
        run_to(2);
        pri_req = 2'b01;
        step();
        pri_req = 2'b00;
        run_to(P + G);
        chk("s6_in_yellow", light_state, 1);
        chk("s6_in_phase1", current_phase, 1);
        drained();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("s6_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        expect_done(1, 0, P);
        expect_done(0, 0, 2 * P);
        run_to(2 * P);
        drained();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
